instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and program loader for the single-cycle MIPS core. It accepts symbolic operations over a valid/ready handshake and packs them into 32-bit MIPS instruction words. Those words are written sequentially into the instruction memory write port. It is the inverse of the instruction decoder and emits exactly the opcode/funct set the decoder understands. It expands the `li` pseudo-instruction into a `lui`/`ori` pair.

## Interface
- `ADDR_W`, default 6: instruction memory address width in words; capacity is 2**ADDR_W words.

- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high
- `restart`  in  1  synchronous; clears the pointer, count and error, and returns the FSM to IDLE
- `in_valid`  in  1  an operation is offered
- `in_ready`  out  1  the block accepts the operation this cycle
- `in_kind`  in  4  operation code, one of:
  - 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLTU
  - 5 LW, 6 SW, 7 BEQ, 8 ADDIU, 9 J
  - 10 LUI, 11 ORI, 12 LI, 13 HALT
  - 14–15 illegal
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register fields
- `in_imm`  in  32  immediate; `[15:0]` for I-type, `[25:0]` for J, full width for LI
- `mem_we`  out  1  write strobe, one cycle per word
- `mem_addr`  out  ADDR_W  word address
- `mem_wdata`  out  32  encoded instruction word
- `count`  out  ADDR_W+1  number of words written since reset or restart
- `full`  out  1  `count == 2**ADDR_W`
- `error`  out  1  sticky; set by an illegal kind or by an LI that does not fit

## Operation
Field layout:
- opcode `[31:26]`, rs `[25:21]`, rt `[20:16]`, rd `[15:11]`
- shamt `[10:6]` is always 0; funct `[5:0]`; imm `[15:0]`; target `[25:0]`

Encodings:
- R-type kinds: opcode 0. funct is ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, SLTU 0x2B.
- LW 0x23, SW 0x2B, BEQ 0x04, ADDIU 0x09, ORI 0x0D: rs, rt, imm.
- LUI 0x0F: rs=0, rt, imm.
- J 0x02: target = `in_imm[25:0]`.
- HALT: J whose target is the word's own address, zero-extended (jump-to-self).
- LI rt, imm32 expands to two words:
  - `lui rt, imm[31:16]`
  - `ori rt, rt, imm[15:0]`

Unused input fields are ignored and their bit positions encode 0.

FSM states:
- IDLE: `in_ready = !full`. On accept:
  - non-LI kind: write one word and stay in IDLE.
  - LI: write the lui word and go to LI_LO.
  - illegal kind: set `error`, write nothing, stay in IDLE.
- LI_LO: `in_ready = 0`. Writes the ori word and returns to IDLE.

Boundaries:
- LI accepted with exactly one free slot: nothing is written, `error` is set, `count` is unchanged.
- Full: `in_ready` stays 0 until `restart` or `reset`. The pointer does not wrap.
- `restart` has priority over `in_valid`. `restart` during LI_LO aborts the pair: the ori word is not written.
- `reset` mid-operation behaves identically to `restart` but is asynchronous.

## Timing
- Reset values:
  - state IDLE, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0
  - `count` 0, `full` 0, `error` 0, `in_ready` 1
- `mem_we`, `mem_addr` and `mem_wdata` are registered.
- Latency is 1 cycle: a word accepted at edge N is presented with `mem_we` = 1 during cycle N+1, at the pointer value held at acceptance.
- LI: lui in cycle N+1, ori in cycle N+2 at address+1. `in_ready` is low during cycle N+1.
- Throughput is one operation per cycle for all kinds except LI, which takes two.
- `count` increments at the same edge that registers each write. `full` is combinational from `count`.
- `error` rises in the cycle after the offending accept.

## Structure
- Shared package `mips_isa_pkg`, also used by the decoder, holds:
  - opcode and funct localparams
  - the `in_kind` enum
  - field bit positions
- Sub-module `instr_word_pack`: purely combinational; maps kind, fields and current address to a 32-bit word plus an illegal flag.
- The top level holds the FSM, the write pointer, the counters and the output registers.

## Test plan
- Reset, then ADDU rs=1 rt=2 rd=3 -> next cycle `mem_we`=1, addr 0, wdata 0x00221821, `count`=1.
- LI rt=8 imm=0x12345678 -> addr 0: 0x3C081234, addr 1: 0x35085678. `in_ready` low exactly one cycle.
- LW rs=29 rt=4 imm=0xFFFC -> 0x8FA4FFFC. SW with the same fields -> 0xAFA4FFFC. BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF.
- `ADDR_W`=2 overflow cases:
  - four ADDIU -> `full`=1, `in_ready`=0.
  - separately, three ADDIU then LI -> `error`=1, `count`=3, no write.
- Five words written, then HALT -> addr 5, wdata 0x08000005.
- Boundary cases:
  - kind 14 -> `error`=1 and no write.
  - LI followed by `restart` during LI_LO -> no ori write; `count`=0 and `error`=0 after restart.
  - `reset` asserted mid-LI -> all outputs at their reset values immediately.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder and decoder:
// opcodes, R-type functs, operation kinds and field positions.
package mips_isa_pkg;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        K_ADDU  = 4'd0,  K_SUBU = 4'd1,  K_AND = 4'd2,  K_OR   = 4'd3,
        K_SLTU  = 4'd4,  K_LW   = 4'd5,  K_SW  = 4'd6,  K_BEQ  = 4'd7,
        K_ADDIU = 4'd8,  K_J    = 4'd9,  K_LUI = 4'd10, K_ORI  = 4'd11,
        K_LI    = 4'd12, K_HALT = 4'd13
    } kind_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: kind + fields + current word address -> 32-bit MIPS word.
// Also produces the ori half of an LI so the top can hold it for the second cycle.
module instr_word_pack
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic [3:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [31:0]       imm,
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       word,
    output logic [31:0]       li_lo_word,
    output logic              illegal
);

    always_comb begin
        word       = '0;
        illegal    = 1'b0;
        li_lo_word = i_word(OP_ORI, rt, rt, imm[15:0]);
        case (kind)
            K_ADDU:  word = r_word(rs, rt, rd, FN_ADDU);
            K_SUBU:  word = r_word(rs, rt, rd, FN_SUBU);
            K_AND:   word = r_word(rs, rt, rd, FN_AND);
            K_OR:    word = r_word(rs, rt, rd, FN_OR);
            K_SLTU:  word = r_word(rs, rt, rd, FN_SLTU);
            K_LW:    word = i_word(OP_LW, rs, rt, imm[15:0]);
            K_SW:    word = i_word(OP_SW, rs, rt, imm[15:0]);
            K_BEQ:   word = i_word(OP_BEQ, rs, rt, imm[15:0]);
            K_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm[15:0]);
            K_ORI:   word = i_word(OP_ORI, rs, rt, imm[15:0]);
            K_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
            K_LI:    word = i_word(OP_LUI, 5'd0, rt, imm[31:16]);
            K_J:     word = {OP_J, imm[25:0]};
            // jump-to-self: target is this word's own address
            K_HALT:  word = {OP_J, {(26-ADDR_W){1'b0}}, addr};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: accepts symbolic ops over valid/ready and
// writes packed MIPS words sequentially into instruction memory.
//
//   state  | meaning
//   IDLE   | ready for a new op while not full
//   LI_LO  | lui half of an LI written; ori half goes out this cycle
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              error
);

    typedef enum logic {IDLE = 1'b0, LI_LO = 1'b1} state_e;

    localparam logic [ADDR_W:0] CAP  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    state_e              state_q, state_d;
    logic [ADDR_W:0]     count_d;
    logic                error_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [31:0]         wdata_d;
    logic [31:0]         lo_q, lo_d;
    logic [31:0]         word, li_lo_word;
    logic                illegal;
    logic [ADDR_W-1:0]   ptr;

    // The pointer never wraps: once count reaches CAP no further writes happen.
    assign ptr      = count[ADDR_W-1:0];
    assign full     = (count == CAP);
    assign in_ready = (state_q == IDLE) && !full;

    instr_word_pack #(.ADDR_W(ADDR_W)) u_pack (
        .kind       (in_kind),
        .rs         (in_rs),
        .rt         (in_rt),
        .rd         (in_rd),
        .imm        (in_imm),
        .addr       (ptr),
        .word       (word),
        .li_lo_word (li_lo_word),
        .illegal    (illegal)
    );

    always_comb begin
        state_d = state_q;
        count_d = count;
        error_d = error;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        lo_d    = lo_q;
        if (restart) begin
            state_d = IDLE;
            count_d = '0;
            error_d = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && !full) begin
                        if (illegal) begin
                            error_d = 1'b1;
                        end else if (in_kind == K_LI && count == LAST) begin
                            error_d = 1'b1;
                        end else begin
                            we_d    = 1'b1;
                            addr_d  = ptr;
                            wdata_d = word;
                            count_d = count + 1'b1;
                            if (in_kind == K_LI) begin
                                state_d = LI_LO;
                                lo_d    = li_lo_word;
                            end
                        end
                    end
                end
                LI_LO: begin
                    we_d    = 1'b1;
                    addr_d  = ptr;
                    wdata_d = lo_q;
                    count_d = count + 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count     <= '0;
            error     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count     <= count_d;
            error     <= error_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a 64-word instance for encodings and a
// 4-word instance for the full / LI-does-not-fit boundaries.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0, restart_s = 1'b0;
    logic        in_valid = 1'b0, in_valid_s = 1'b0;
    logic [3:0]  kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [31:0] imm = '0;

    logic        ready, we, full, error;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [6:0]  count;

    logic        ready_s, we_s, full_s, error_s;
    logic [1:0]  addr_s;
    logic [31:0] wdata_s;
    logic [2:0]  count_s;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(ready),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm),
        .mem_we(we), .mem_addr(addr), .mem_wdata(wdata), .count(count), .full(full), .error(error)
    );

    instr_encoder #(.ADDR_W(2)) dut_s (
        .clk(clk), .reset(reset), .restart(restart_s), .in_valid(in_valid_s), .in_ready(ready_s),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm),
        .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wdata_s), .count(count_s), .full(full_s), .error(error_s)
    );

    // Offer one op for one cycle; returns 1 ns after the edge, when the registered write is visible.
    task automatic op(input bit sm, input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [31:0] im);
        kind = k; rs = s; rt = t; rd = d; imm = im;
        if (sm) in_valid_s = 1'b1; else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid_s = 1'b0;
    endtask

    task automatic do_restart(input bit sm);
        if (sm) restart_s = 1'b1; else restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0; restart_s = 1'b0;
    endtask

    task automatic test_reset;
        nvec++; if (we !== 1'b0) begin nerr++; $display("FAIL reset_we got %b want 0", we); end
        nvec++; if (addr !== 6'd0) begin nerr++; $display("FAIL reset_addr got %0d want 0", addr); end
        nvec++; if (wdata !== 32'h0) begin nerr++; $display("FAIL reset_wdata got %h want 0", wdata); end
        nvec++; if (count !== 7'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", count); end
        nvec++; if (full !== 1'b0 || error !== 1'b0) begin nerr++; $display("FAIL reset_flags got full=%b err=%b want 0 0", full, error); end
        nvec++; if (ready !== 1'b1 || ready_s !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b/%b want 1/1", ready, ready_s); end
        #2 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rtype;
        logic [31:0] exp [5];
        exp = '{32'h00221821, 32'h00221823, 32'h00221824, 32'h00221825, 32'h0022182B};
        for (int i = 0; i < 5; i++) begin
            op(1'b0, 4'(i), 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF);
            nvec++; if (we !== 1'b1 || addr !== 6'(i) || wdata !== exp[i])
                begin nerr++; $display("FAIL rtype%0d got we=%b addr=%0d wdata=%h want 1 %0d %h", i, we, addr, wdata, i, exp[i]); end
            nvec++; if (count !== 7'(i + 1)) begin nerr++; $display("FAIL rtype%0d_count got %0d want %0d", i, count, i + 1); end
        end
        @(posedge clk); #1;
        nvec++; if (we !== 1'b0) begin nerr++; $display("FAIL rtype_idle_we got %b want 0", we); end
    endtask

    task automatic test_li;
        do_restart(1'b0);
        op(1'b0, 4'd12, 5'd0, 5'd8, 5'd0, 32'h12345678);
        nvec++; if (we !== 1'b1 || addr !== 6'd0 || wdata !== 32'h3C081234)
            begin nerr++; $display("FAIL li_lui got we=%b addr=%0d wdata=%h want 1 0 3c081234", we, addr, wdata); end
        nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL li_ready_low got %b want 0", ready); end
        @(posedge clk); #1;
        nvec++; if (we !== 1'b1 || addr !== 6'd1 || wdata !== 32'h35085678)
            begin nerr++; $display("FAIL li_ori got we=%b addr=%0d wdata=%h want 1 1 35085678", we, addr, wdata); end
        nvec++; if (ready !== 1'b1 || count !== 7'd2) begin nerr++; $display("FAIL li_after got ready=%b count=%0d want 1 2", ready, count); end
    endtask

    task automatic test_itype;
        logic [3:0]  k  [6];
        logic [4:0]  s  [6];
        logic [4:0]  t  [6];
        logic [31:0] im [6];
        logic [31:0] exp[6];
        k   = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        s   = '{5'd29, 5'd29, 5'd1, 5'd0, 5'd7, 5'd5};
        t   = '{5'd4, 5'd4, 5'd2, 5'd1, 5'd7, 5'd3};
        im  = '{32'h0000FFFC, 32'h0000FFFC, 32'h0000FFFF, 32'h00000005, 32'hFC123456, 32'h0000ABCD};
        exp = '{32'h8FA4FFFC, 32'hAFA4FFFC, 32'h1022FFFF, 32'h24010005, 32'h08123456, 32'h3C03ABCD};
        for (int i = 0; i < 6; i++) begin
            op(1'b0, k[i], s[i], t[i], 5'd31, im[i]);
            nvec++; if (we !== 1'b1 || addr !== 6'(i + 2) || wdata !== exp[i])
                begin nerr++; $display("FAIL itype_k%0d got we=%b addr=%0d wdata=%h want 1 %0d %h", k[i], we, addr, wdata, i + 2, exp[i]); end
        end
        op(1'b0, 4'd11, 5'd2, 5'd3, 5'd9, 32'hAAAA00FF);
        nvec++; if (wdata !== 32'h344300FF || count !== 7'd9)
            begin nerr++; $display("FAIL ori got wdata=%h count=%0d want 344300ff 9", wdata, count); end
    endtask

    task automatic test_halt;
        do_restart(1'b0);
        for (int i = 0; i < 5; i++) op(1'b0, 4'd8, 5'd0, 5'd1, 5'd0, 32'(i));
        op(1'b0, 4'd13, 5'd3, 5'd4, 5'd5, 32'hFFFFFFFF);
        nvec++; if (we !== 1'b1 || addr !== 6'd5 || wdata !== 32'h08000005)
            begin nerr++; $display("FAIL halt got we=%b addr=%0d wdata=%h want 1 5 08000005", we, addr, wdata); end
        nvec++; if (count !== 7'd6) begin nerr++; $display("FAIL halt_count got %0d want 6", count); end
    endtask

    task automatic test_illegal;
        do_restart(1'b0);
        op(1'b0, 4'd14, 5'd1, 5'd2, 5'd3, 32'h0);
        nvec++; if (we !== 1'b0 || error !== 1'b1 || count !== 7'd0)
            begin nerr++; $display("FAIL illegal14 got we=%b err=%b count=%0d want 0 1 0", we, error, count); end
        op(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        nvec++; if (we !== 1'b1 || error !== 1'b1 || wdata !== 32'h00221821)
            begin nerr++; $display("FAIL illegal_sticky got we=%b err=%b wdata=%h want 1 1 00221821", we, error, wdata); end
        op(1'b0, 4'd15, 5'd1, 5'd2, 5'd3, 32'h0);
        nvec++; if (we !== 1'b0 || count !== 7'd1)
            begin nerr++; $display("FAIL illegal15 got we=%b count=%0d want 0 1", we, count); end
    endtask

    task automatic test_li_restart;
        do_restart(1'b0);
        op(1'b0, 4'd14, 5'd0, 5'd0, 5'd0, 32'h0);
        op(1'b0, 4'd12, 5'd0, 5'd8, 5'd0, 32'h12345678);
        nvec++; if (count !== 7'd1 || error !== 1'b1)
            begin nerr++; $display("FAIL lirst_pre got count=%0d err=%b want 1 1", count, error); end
        do_restart(1'b0);
        nvec++; if (we !== 1'b0 || count !== 7'd0 || error !== 1'b0 || ready !== 1'b1)
            begin nerr++; $display("FAIL lirst_abort got we=%b count=%0d err=%b ready=%b want 0 0 0 1", we, count, error, ready); end
        @(posedge clk); #1;
        nvec++; if (we !== 1'b0) begin nerr++; $display("FAIL lirst_no_ori got we=%b want 0", we); end
    endtask

    task automatic test_reset_mid_li;
        do_restart(1'b0);
        op(1'b0, 4'd15, 5'd0, 5'd0, 5'd0, 32'h0);
        op(1'b0, 4'd12, 5'd0, 5'd8, 5'd0, 32'h12345678);
        reset = 1'b1;
        #1;
        nvec++; if (we !== 1'b0 || addr !== 6'd0 || wdata !== 32'h0)
            begin nerr++; $display("FAIL rstli_mem got we=%b addr=%0d wdata=%h want 0 0 0", we, addr, wdata); end
        nvec++; if (count !== 7'd0 || error !== 1'b0 || full !== 1'b0 || ready !== 1'b1)
            begin nerr++; $display("FAIL rstli_state got count=%0d err=%b full=%b ready=%b want 0 0 0 1", count, error, full, ready); end
        #2 reset = 1'b0;
        @(posedge clk); #1;
        nvec++; if (we !== 1'b0 || count !== 7'd0) begin nerr++; $display("FAIL rstli_after got we=%b count=%0d want 0 0", we, count); end
    endtask

    task automatic test_small_full;
        do_restart(1'b1);
        for (int i = 0; i < 4; i++) op(1'b1, 4'd8, 5'd0, 5'd1, 5'd0, 32'(i));
        nvec++; if (we_s !== 1'b1 || addr_s !== 2'd3 || wdata_s !== 32'h24010003)
            begin nerr++; $display("FAIL full_last got we=%b addr=%0d wdata=%h want 1 3 24010003", we_s, addr_s, wdata_s); end
        nvec++; if (full_s !== 1'b1 || ready_s !== 1'b0 || count_s !== 3'd4)
            begin nerr++; $display("FAIL full_flags got full=%b ready=%b count=%0d want 1 0 4", full_s, ready_s, count_s); end
        op(1'b1, 4'd8, 5'd0, 5'd1, 5'd0, 32'h7);
        nvec++; if (we_s !== 1'b0 || count_s !== 3'd4 || ready_s !== 1'b0)
            begin nerr++; $display("FAIL full_hold got we=%b count=%0d ready=%b want 0 4 0", we_s, count_s, ready_s); end
        do_restart(1'b1);
        nvec++; if (full_s !== 1'b0 || ready_s !== 1'b1 || count_s !== 3'd0)
            begin nerr++; $display("FAIL full_restart got full=%b ready=%b count=%0d want 0 1 0", full_s, ready_s, count_s); end
    endtask

    task automatic test_small_li_nofit;
        do_restart(1'b1);
        for (int i = 0; i < 3; i++) op(1'b1, 4'd8, 5'd0, 5'd1, 5'd0, 32'(i));
        op(1'b1, 4'd12, 5'd0, 5'd8, 5'd0, 32'h12345678);
        nvec++; if (we_s !== 1'b0 || error_s !== 1'b1 || count_s !== 3'd3 || ready_s !== 1'b1)
            begin nerr++; $display("FAIL li_nofit got we=%b err=%b count=%0d ready=%b want 0 1 3 1", we_s, error_s, count_s, ready_s); end
        @(posedge clk); #1;
        nvec++; if (we_s !== 1'b0 || count_s !== 3'd3)
            begin nerr++; $display("FAIL li_nofit_after got we=%b count=%0d want 0 3", we_s, count_s); end
    endtask

    initial begin
        #1;
        test_reset();
        test_rtype();
        test_li();
        test_itype();
        test_halt();
        test_illegal();
        test_li_restart();
        test_reset_mid_li();
        test_small_full();
        test_small_li_nofit();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
